simon_tone: RTL and testbench



---
 rtl/simon_pkg.sv | 39 +++
 rtl/tone_divider.sv | 31 +++
 rtl/simon_tone.sv | 165 ++++++++++++++++
 tb/tb_simon_tone.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - note codes, FSM states and the tone half-period helper for simon_tone
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [2:0] NOTE_RED    = 3'd0;
  localparam logic [2:0] NOTE_GREEN  = 3'd1;
  localparam logic [2:0] NOTE_BLUE   = 3'd2;
  localparam logic [2:0] NOTE_YELLOW = 3'd3;
  localparam logic [2:0] NOTE_LOSE   = 3'd4;
  localparam logic [2:0] NOTE_OFF    = 3'd5;

  // Half-period in clock cycles for a note; silence codes map to 0.
  function automatic int unsigned half_period(
    input logic [2:0]  n,
    input int unsigned clk_hz,
    input int unsigned red_hz,
    input int unsigned green_hz,
    input int unsigned blue_hz,
    input int unsigned yellow_hz,
    input int unsigned lose_hz
  );
    int unsigned hz;
    case (n)
      NOTE_RED:    hz = red_hz;
      NOTE_GREEN:  hz = green_hz;
      NOTE_BLUE:   hz = blue_hz;
      NOTE_YELLOW: hz = yellow_hz;
      NOTE_LOSE:   hz = lose_hz;
      default:     hz = 0;
    endcase
    return (hz == 0) ? 0 : clk_hz / (2 * hz);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - half-period counter and phase flip-flop producing the square wave
module tone_divider #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] half_q,
  input  logic             restart,
  input  logic             enable,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;

  // Count to half_q-1, then toggle phase; restart or disable parks the wave low at count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart || !enable) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == half_q - CNT_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/simon_tone.sv
// rtl/simon_tone.sv - Simon tone back end: note FSM, amplifier release, optional SIMON_TONE_SWEEP_EN lose glide
module simon_tone
  import simon_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned RED_HZ      = 310,
  parameter int unsigned GREEN_HZ    = 415,
  parameter int unsigned BLUE_HZ     = 209,
  parameter int unsigned YELLOW_HZ   = 252,
  parameter int unsigned LOSE_HZ     = 42,
  parameter int unsigned RELEASE_CYC = 1000000,
  parameter int          CNT_W       = 21
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] note,
  output logic       AUD_PWM,
  output logic       AUD_SD,
  output logic       playing
);

  localparam logic [CNT_W-1:0] HALF_RED    =
    CNT_W'(half_period(NOTE_RED,    CLK_HZ, RED_HZ, GREEN_HZ, BLUE_HZ, YELLOW_HZ, LOSE_HZ));
  localparam logic [CNT_W-1:0] HALF_GREEN  =
    CNT_W'(half_period(NOTE_GREEN,  CLK_HZ, RED_HZ, GREEN_HZ, BLUE_HZ, YELLOW_HZ, LOSE_HZ));
  localparam logic [CNT_W-1:0] HALF_BLUE   =
    CNT_W'(half_period(NOTE_BLUE,   CLK_HZ, RED_HZ, GREEN_HZ, BLUE_HZ, YELLOW_HZ, LOSE_HZ));
  localparam logic [CNT_W-1:0] HALF_YELLOW =
    CNT_W'(half_period(NOTE_YELLOW, CLK_HZ, RED_HZ, GREEN_HZ, BLUE_HZ, YELLOW_HZ, LOSE_HZ));
  localparam logic [CNT_W-1:0] HALF_LOSE   =
    CNT_W'(half_period(NOTE_LOSE,   CLK_HZ, RED_HZ, GREEN_HZ, BLUE_HZ, YELLOW_HZ, LOSE_HZ));
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_CYC - 1);

  state_t           state, state_n;
  logic [2:0]       cur_note, cur_note_n;
  logic [CNT_W-1:0] half_q, half_n, half_sel;
  logic [CNT_W-1:0] rel, rel_n;
  logic             active;
  logic             valid, restart, enable;

`ifdef SIMON_TONE_SWEEP_EN
  localparam int unsigned      SWEEP_CYC  = CLK_HZ / 100;
  localparam int               SWEEP_W    = $clog2(SWEEP_CYC + 1);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_CYC - 1);
  localparam logic [CNT_W-1:0] SWEEP_STEP = HALF_LOSE >> 6;
  localparam logic [CNT_W-1:0] HALF_MAX   = '1;

  logic [SWEEP_W-1:0] sweep_tick, sweep_tick_n;
`endif

  assign valid   = (note <= NOTE_LOSE);
  assign AUD_SD  = active;
  assign playing = active;

  // Select the half-period of the incoming note.
  always_comb begin
    half_sel = HALF_RED;
    case (note)
      NOTE_GREEN:  half_sel = HALF_GREEN;
      NOTE_BLUE:   half_sel = HALF_BLUE;
      NOTE_YELLOW: half_sel = HALF_YELLOW;
      NOTE_LOSE:   half_sel = HALF_LOSE;
      default:     half_sel = HALF_RED;
    endcase
  end

  // Next-state logic: load on a new valid note, hold tone on same note, release on silence.
  always_comb begin
    state_n    = state;
    cur_note_n = cur_note;
    half_n     = half_q;
    rel_n      = rel;
    restart    = 1'b0;
    enable     = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          state_n    = PLAY;
          cur_note_n = note;
          half_n     = half_sel;
          rel_n      = '0;
          restart    = 1'b1;
        end
      end
      PLAY: begin
        if (!valid) begin
          state_n    = RELEASE;
          cur_note_n = NOTE_OFF;
          rel_n      = '0;
        end else if (note != cur_note) begin
          cur_note_n = note;
          half_n     = half_sel;
          restart    = 1'b1;
        end else begin
          enable     = 1'b1;
        end
      end
      RELEASE: begin
        if (valid) begin
          state_n    = PLAY;
          cur_note_n = note;
          half_n     = half_sel;
          rel_n      = '0;
          restart    = 1'b1;
        end else if (rel == REL_LAST) begin
          state_n    = IDLE;
          rel_n      = '0;
        end else begin
          rel_n      = rel + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SIMON_TONE_SWEEP_EN
    sweep_tick_n = '0;
    if (enable && cur_note == NOTE_LOSE) begin
      if (sweep_tick == SWEEP_LAST) begin
        half_n = (half_q > HALF_MAX - SWEEP_STEP) ? HALF_MAX : half_q + SWEEP_STEP;
      end else begin
        sweep_tick_n = sweep_tick + SWEEP_W'(1);
      end
    end
`endif
  end

  // FSM, note, half-period and release registers; amplifier enable follows the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cur_note <= NOTE_OFF;
      half_q   <= '0;
      rel      <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      cur_note <= cur_note_n;
      half_q   <= half_n;
      rel      <= rel_n;
      active   <= (state_n != IDLE);
    end
  end

`ifdef SIMON_TONE_SWEEP_EN
  // Glide tick counter, running only while the lose tone holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sweep_tick <= '0;
    end else begin
      sweep_tick <= sweep_tick_n;
    end
  end
`endif

  tone_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk     (CLK),
    .rst     (RST),
    .half_q  (half_q),
    .restart (restart),
    .enable  (enable),
    .phase   (AUD_PWM)
  );

endmodule

// File: tb/tb_simon_tone.sv
// tb/tb_simon_tone.sv - scoreboard bench for simon_tone against a time-based reference model
module tb_simon_tone;

  localparam int unsigned CLK_HZ      = 100000;
  localparam int unsigned RELEASE_CYC = 50;
  localparam int          CNT_W       = 21;

  typedef struct packed {
    logic pwm;
    logic sd;
    logic ply;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] note = 3'd5;
  logic       AUD_PWM, AUD_SD, playing;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  int unsigned hz_tab[5] = '{310, 415, 209, 252, 42};

  // reference model: 0 idle, 1 tone, 2 release; m_t = cycles since tone start
  int m_mode = 0;
  int m_cur  = 5;
  int m_half = 1;
  int m_t    = 0;
  int m_rel  = 0;

  simon_tone #(
    .CLK_HZ      (CLK_HZ),
    .RELEASE_CYC (RELEASE_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .note    (note),
    .AUD_PWM (AUD_PWM),
    .AUD_SD  (AUD_SD),
    .playing (playing)
  );

  always #5 CLK = ~CLK;

  task automatic check_all(input exp_t e, input string tag);
    compared += 3;
    if (AUD_PWM !== e.pwm) begin
      mismatched++;
      $display("FAIL %s AUD_PWM got %b want %b at %0t", tag, AUD_PWM, e.pwm, $time);
    end
    if (AUD_SD !== e.sd) begin
      mismatched++;
      $display("FAIL %s AUD_SD got %b want %b at %0t", tag, AUD_SD, e.sd, $time);
    end
    if (playing !== e.ply) begin
      mismatched++;
      $display("FAIL %s playing got %b want %b at %0t", tag, playing, e.ply, $time);
    end
  endtask

  task automatic model_start(input int n);
    m_mode = 1;
    m_cur  = n;
    m_half = int'(CLK_HZ / (2 * hz_tab[n]));
    m_t    = 0;
  endtask

  task automatic model_step(input int n);
    bit v;
    v = (n <= 4);
    case (m_mode)
      0: if (v) model_start(n);
      1: begin
        if (!v) begin
          m_mode = 2;
          m_rel  = 0;
          m_cur  = 5;
        end else if (n != m_cur) begin
          model_start(n);
        end else begin
          m_t++;
        end
      end
      default: begin
        if (v) begin
          model_start(n);
        end else begin
          m_rel++;
          if (m_rel == int'(RELEASE_CYC)) m_mode = 0;
        end
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pwm = (m_mode == 1) && (((m_t / m_half) % 2) == 1);
    e.sd  = (m_mode != 0);
    e.ply = (m_mode != 0);
    return e;
  endfunction

  // one clock of stimulus; expectation is for the outputs after the next edge
  task automatic drive(input int n, input bit r);
    @(posedge CLK);
    #2;
    note = 3'(n);
    if (r) begin
      RST    = 1'b1;
      m_mode = 0;
      m_cur  = 5;
      m_t    = 0;
      m_rel  = 0;
      #1;
      check_all('0, "async_rst");
    end else begin
      RST = 1'b0;
      model_step(n);
    end
    q.push_back(model_out());
  endtask

  task automatic drive_hold(input int n, input int len);
    repeat (len) drive(n, 1'b0);
  endtask

  // monitor: pop and compare once per cycle, just after the active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e, "mon");
      end
    end
  end

  initial begin
    int n;
    int len;
    repeat (3) drive(5, 1'b1);
    drive_hold(0, 241);
    drive_hold(1, 300);
    drive_hold(3, 200);
    drive_hold(5, 60);
    drive_hold(2, 100);
    drive_hold(6, 60);
    drive_hold(0, 100);
    drive_hold(7, 60);
    drive_hold(1, 50);
    drive_hold(5, 20);
    drive_hold(2, 500);
    drive_hold(4, 600);
    repeat (2) drive(4, 1'b1);
    drive_hold(4, 2500);
    for (int i = 0; i < 80; i++) begin
      n   = int'($urandom_range(0, 7));
      len = int'($urandom_range(1, ($urandom_range(0, 1) == 1) ? 30 : 400));
      drive_hold(n, len);
      if ($urandom_range(0, 19) == 0) drive(n, 1'b1);
    end
    drive_hold(5, 60);
    repeat (3) @(posedge CLK);
    #3;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain queue size got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
